ps2_rx: RTL

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered clock, 11-bit frame FSM, timeout.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err
);

   localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   state_e           state_q, state_d;
   logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic             filt_q, filt_d;
   logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
   logic [TmoW-1:0]  tmo_q, tmo_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             fall, good, timeout;
`ifdef PS2_PARITY_CHECK_EN
   logic             parity_q, parity_d;
`endif

   // Level only moves after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
         else filt_cnt_d = filt_cnt_q + 1'b1;
      end
   end

   assign fall = filt_q & ~filt_d;

`ifdef PS2_PARITY_CHECK_EN
   assign good = dat_s2_q & (^{shift_q, parity_q});
`else
   assign good = dat_s2_q;
`endif

   assign timeout = (state_q != StIdle) && (tmo_q == TmoW'(TIMEOUT_CYCLES)) && !fall;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      tmo_d     = tmo_q;
`ifdef PS2_PARITY_CHECK_EN
      parity_d  = parity_q;
`endif
      if (fall || state_q == StIdle) tmo_d = '0;
      else if (tmo_q != TmoW'(TIMEOUT_CYCLES)) tmo_d = tmo_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            if (fall && !dat_s2_q) begin
               state_d   = StData;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (fall) begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = StParity;
            end
         end
         StParity: begin
            if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
               parity_d = dat_s2_q;
`endif
               state_d  = StStop;
            end
         end
         StStop: begin
            if (fall) begin
               state_d = StIdle;
               if (good) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (timeout) begin
         state_d = StIdle;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         tmo_q      <= '0;
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
         tmo_q      <= tmo_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign frame_err  = err_q;

endmodule
